ifu_fetch_buf: RTL and testbench
================================

Name: ifu_fetch_buf

Overview:
- Fetch stage directly downstream of the PC generator.
- Takes the current PC and issues in-order instruction-memory read requests over a valid/ready handshake.
- Matches returning responses to their request PCs and buffers them in a small FIFO that feeds decode.
- On a redirect it flushes buffered instructions and discards responses still in flight. It raises a PC-stall request whenever a fetch cannot be issued.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction word width.
- DEPTH, 4, entries of instruction buffer; also the cap on outstanding+buffered fetches (power of two, ≥2).
- CNT_W, 3, width of occupancy/outstanding counters (must hold DEPTH).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- pc_i  input  ADDR_W  PC to fetch this cycle (from PC generator).
- jump_flag_i  input  1  redirect/flush, active-high.
- hold_flag_i  input  3  pipeline hold level; ≥ Hold_Pc blocks new fetches.
- pc_stall_o  output  1  1 = PC generator must not advance this cycle.
- mem_req_valid_o  output  1  fetch request valid.
- mem_req_ready_i  input  1  memory accepts request.
- mem_req_addr_o  output  ADDR_W  fetch address (= pc_i).
- mem_rsp_valid_i  input  1  read data valid; responses return in request order, ≥1 cycle after acceptance.
- mem_rsp_data_i  input  DATA_W  read data.
- inst_valid_o  output  1  buffer head valid toward decode.
- inst_ready_i  input  1  decode consumes head.
- inst_o  output  DATA_W  head instruction.
- inst_addr_o  output  ADDR_W  PC of head instruction.

Behaviour:
- Reset (rst=0, async) clears all state:
  - mem_req_valid_o=0, inst_valid_o=0, pc_stall_o=1.
  - inst_o=0, inst_addr_o=0.
  - Counters, pointers and discard count all 0.
- State:
  - Data FIFO: DEPTH entries of {addr, inst}.
  - Pending-address queue: DEPTH entries of issued PCs.
  - outstanding counter (accepted, not yet returned).
  - discard counter.
- Credit: can_issue = (outstanding + fifo_count + discard) < DEPTH, and hold_flag_i < Hold_Pc, and jump_flag_i=0.
- mem_req_valid_o = can_issue (combinational); mem_req_addr_o = pc_i.
- Accept = mem_req_valid_o & mem_req_ready_i.
  - On accept, pc_i is pushed to the pending queue and outstanding increments.
- pc_stall_o = ~accept. The PC moves only when its fetch is accepted, so no address is skipped.
- Response handling (mem_rsp_valid_i=1):
  - If discard>0: response dropped, discard decrements, pending queue untouched.
  - Else: pop the pending queue head and push {head addr, data} into the data FIFO; outstanding decrements.
  - Credit guarantees the FIFO is never full here. A response with outstanding=discard=0 is a protocol error: ignored, no state change.
- Decode side:
  - inst_valid_o = fifo_count≠0; inst_o/inst_addr_o show the head combinationally from registered storage.
  - inst_valid_o & inst_ready_i pops.
  - Push and pop in the same cycle leave count unchanged. Pop on empty is a no-op.
- Flush (jump_flag_i=1):
  - Same cycle: no request issued, no inst pop honoured.
  - Next state: fifo_count=0, pending queue cleared, discard = outstanding, outstanding=0.
  - A response arriving on the flush cycle counts against the pre-flush outstanding (discard = outstanding−1 in that case) or decrements discard if discard>0.
- Flush with discard already nonzero: discard accumulates (new discard = old discard + outstanding, minus a same-cycle response).
- Throughput: with an always-ready memory (1-cycle response) and ready decode, one instruction per cycle after a 2-cycle fill latency (request cycle N → inst_valid_o cycle N+2).
- Counters wrap-free: all bounded by DEPTH by construction. Pointers are log2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset then release, mem_req_ready_i=1, 1-cycle responses, pc_i stepping 0x0,0x4,0x8…, inst_ready_i=1 → first inst_valid_o two cycles after first accept with inst_addr_o=0x0; then one instruction per cycle in PC order.
- inst_ready_i=0 with DEPTH=4 → exactly 4 accepts, then mem_req_valid_o=0 and pc_stall_o=1; one pop re-enables exactly one fetch.
- 3 requests outstanding (responses delayed), jump_flag_i=1 for one cycle with pc_i=0x100 after → the 3 late responses are dropped; first inst_addr_o after flush is 0x100 with matching data.
- Response arriving on the jump cycle with outstanding=2 → discard=1; only one following response dropped.
- mem_req_ready_i toggled 1/0 randomly → pc_stall_o tracks ~accept each cycle; no PC duplicated or skipped at decode.
- Assert rst low mid-stream with FIFO holding 2 entries → outputs clear immediately (asynchronously); after release, the first inst_addr_o is the first pc_i accepted post-reset.

Source files
------------

// File: rtl/ifu_fetch_buf_if.sv
// Fetch-buffer bus: instruction-memory request/response channel plus the
// instruction stream handed to decode.
interface ifu_fetch_buf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic              mem_rsp_valid_i;
    logic [DATA_W-1:0] mem_rsp_data_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;

    modport master (
        output mem_req_valid_o, mem_req_addr_o, inst_valid_o, inst_o, inst_addr_o,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, inst_ready_i
    );

    modport slave (
        input  mem_req_valid_o, mem_req_addr_o, inst_valid_o, inst_o, inst_addr_o,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, inst_ready_i
    );
endinterface

// File: rtl/ifu_fetch_buf.sv
// Fetch stage: issues in-order instruction reads for the current PC, pairs the
// returning data with its PC and queues it for decode; redirects flush and discard.
module ifu_fetch_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_flag_i,
    input  logic [2:0]        hold_flag_i,
    output logic              pc_stall_o,
    ifu_fetch_buf_if.master   bus
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [2:0]       HOLD_PC = 3'd1;
    localparam logic [CNT_W+1:0] DEPTH_C = (CNT_W+2)'(DEPTH);

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] pend_addr [DEPTH];

    logic [PTR_W-1:0] fifo_wr_ptr, fifo_rd_ptr, pend_wr_ptr, pend_rd_ptr;
    logic [CNT_W-1:0] fifo_count, outstanding, discard;
    logic [CNT_W-1:0] fifo_count_n, outstanding_n, discard_n;
    logic [CNT_W+1:0] credit_used;
    logic             can_issue, accept, rsp_take, rsp_drop, pop;

    // Every slot is either in flight, buffered, or owed to a discarded response;
    // the request is also held off while reset is asserted.
    assign credit_used = (CNT_W+2)'(outstanding) + (CNT_W+2)'(fifo_count) + (CNT_W+2)'(discard);
    assign can_issue   = rst && (credit_used < DEPTH_C) && (hold_flag_i < HOLD_PC) && !jump_flag_i;
    assign accept      = can_issue && bus.mem_req_ready_i;
    assign rsp_drop    = bus.mem_rsp_valid_i && (discard != '0);
    assign rsp_take    = bus.mem_rsp_valid_i && (discard == '0) && (outstanding != '0);
    assign pop         = (fifo_count != '0) && bus.inst_ready_i && !jump_flag_i;

    assign bus.mem_req_valid_o = can_issue;
    assign bus.mem_req_addr_o  = pc_i;
    assign pc_stall_o          = !accept;
    assign bus.inst_valid_o    = (fifo_count != '0);
    assign bus.inst_o          = bus.inst_valid_o ? fifo_data[fifo_rd_ptr] : '0;
    assign bus.inst_addr_o     = bus.inst_valid_o ? fifo_addr[fifo_rd_ptr] : '0;

    // On a redirect every response still in flight becomes one to throw away,
    // less any response that lands on the redirect cycle itself.
    always_comb begin
        fifo_count_n  = fifo_count;
        outstanding_n = outstanding;
        discard_n     = discard;
        if (jump_flag_i) begin
            fifo_count_n  = '0;
            outstanding_n = '0;
            discard_n     = discard + outstanding
                          - CNT_W'(bus.mem_rsp_valid_i && ((discard != '0) || (outstanding != '0)));
        end else begin
            fifo_count_n  = fifo_count + CNT_W'(rsp_take) - CNT_W'(pop);
            outstanding_n = outstanding + CNT_W'(accept) - CNT_W'(rsp_take);
            discard_n     = discard - CNT_W'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_count  <= '0;
            outstanding <= '0;
            discard     <= '0;
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            pend_wr_ptr <= '0;
            pend_rd_ptr <= '0;
        end else begin
            fifo_count  <= fifo_count_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            if (jump_flag_i) begin
                fifo_wr_ptr <= '0;
                fifo_rd_ptr <= '0;
                pend_wr_ptr <= '0;
                pend_rd_ptr <= '0;
            end else begin
                fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(rsp_take);
                fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(pop);
                pend_wr_ptr <= pend_wr_ptr + PTR_W'(accept);
                pend_rd_ptr <= pend_rd_ptr + PTR_W'(rsp_take);
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_addr[pend_wr_ptr] <= pc_i;
        end
        if (rsp_take && !jump_flag_i) begin
            fifo_addr[fifo_wr_ptr] <= pend_addr[pend_rd_ptr];
            fifo_data[fifo_wr_ptr] <= bus.mem_rsp_data_i;
        end
    end
endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Directed bench for ifu_fetch_buf: a vector table for fill/backpressure plus
// hand-written flush, random-ready and async-reset sequences.
module tb_ifu_fetch_buf;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic        ready;
        logic        inst_ready;
        logic [2:0]  hold;
        logic        exp_req_valid;
        logic        exp_stall;
        logic        exp_inst_valid;
        logic [31:0] exp_inst_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        jump_flag;
    logic [2:0]  hold_flag;
    logic        pc_stall;
    logic        rsp_en;
    logic [31:0] mem_q[$];
    vec_t        vecs[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;

    ifu_fetch_buf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    ifu_fetch_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc),
        .jump_flag_i (jump_flag),
        .hold_flag_i (hold_flag),
        .pc_stall_o  (pc_stall),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input logic [31:0] p, input logic rdy, input logic irdy,
                                input logic [2:0] hld, input logic erv, input logic est,
                                input logic eiv, input logic [31:0] eia);
        vec_t v;
        v.pc = p; v.ready = rdy; v.inst_ready = irdy; v.hold = hld;
        v.exp_req_valid = erv; v.exp_stall = est; v.exp_inst_valid = eiv; v.exp_inst_addr = eia;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] p, input logic rdy, input logic irdy,
                                 input logic jmp, input logic [2:0] hld);
        pc                  = p;
        bus.mem_req_ready_i = rdy;
        bus.inst_ready_i    = irdy;
        jump_flag           = jmp;
        hold_flag           = hld;
        #1;
    endtask

    // One clock of the memory model: in-order, at least one cycle of latency.
    task automatic tick();
        logic        acc;
        logic        fire;
        logic [31:0] acc_pc;
        acc    = bus.mem_req_valid_o && bus.mem_req_ready_i;
        fire   = bus.mem_rsp_valid_i;
        acc_pc = pc;
        @(posedge clk);
        #1;
        if (fire && mem_q.size() > 0) void'(mem_q.pop_front());
        if (acc) mem_q.push_back(acc_pc);
        bus.mem_rsp_valid_i = rsp_en && (mem_q.size() > 0);
        bus.mem_rsp_data_i  = (mem_q.size() > 0) ? mem_word(mem_q[0]) : '0;
    endtask

    task automatic check_reset(input string name);
        checkOutput({name, "_req_valid"},  32'(bus.mem_req_valid_o), 32'd0);
        checkOutput({name, "_stall"},      32'(pc_stall),             32'd1);
        checkOutput({name, "_inst_valid"}, 32'(bus.inst_valid_o),     32'd0);
        checkOutput({name, "_inst"},       bus.inst_o,                32'd0);
        checkOutput({name, "_inst_addr"},  bus.inst_addr_o,           32'd0);
    endtask

    task automatic drain();
        rsp_en = 1'b1;
        applyStimulus(pc, 1'b0, 1'b1, 1'b0, 3'd0);
        repeat (8) tick();
        applyStimulus(pc, 1'b0, 1'b1, 1'b0, 3'd0);
        checkOutput("drain_empty", 32'(bus.inst_valid_o), 32'd0);
    endtask

    // Lets the front end run freely and checks the first instruction decode sees.
    task automatic runUntilInst(input logic [31:0] start, input string name);
        logic [31:0] p;
        logic        stalled;
        bit          seen;
        p    = start;
        seen = 0;
        for (int c = 0; c < 24 && !seen; c++) begin
            applyStimulus(p, 1'b1, 1'b1, 1'b0, 3'd0);
            if (bus.inst_valid_o) begin
                seen = 1;
                checkOutput({name, "_addr"}, bus.inst_addr_o, start);
                checkOutput({name, "_data"}, bus.inst_o, mem_word(start));
            end
            stalled = pc_stall;
            tick();
            if (!stalled) p += 32'd4;
        end
        if (!seen) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s_timeout: got no inst_valid_o, expected inst at 0x%08h", name, start);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] p;
        logic [31:0] exp_next;
        logic        r;
        logic        stalled;

        rst                 = 1'b0;
        rsp_en              = 1'b1;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;
        applyStimulus(32'h0, 1'b1, 1'b1, 1'b0, 3'd0);
        check_reset("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Fill latency, hold, backpressure to DEPTH and single-credit refill.
        vecs.push_back(mk(32'h00, 1, 1, 3'd0, 1, 0, 0, 32'h00));
        vecs.push_back(mk(32'h04, 1, 1, 3'd0, 1, 0, 0, 32'h00));
        vecs.push_back(mk(32'h08, 1, 1, 3'd0, 1, 0, 1, 32'h00));
        vecs.push_back(mk(32'h0C, 1, 1, 3'd0, 1, 0, 1, 32'h04));
        vecs.push_back(mk(32'h10, 1, 1, 3'd1, 0, 1, 1, 32'h08));
        vecs.push_back(mk(32'h10, 1, 1, 3'd0, 1, 0, 1, 32'h0C));
        vecs.push_back(mk(32'h14, 1, 0, 3'd0, 1, 0, 0, 32'h00));
        vecs.push_back(mk(32'h18, 1, 0, 3'd0, 1, 0, 1, 32'h10));
        vecs.push_back(mk(32'h1C, 1, 0, 3'd0, 1, 0, 1, 32'h10));
        vecs.push_back(mk(32'h20, 1, 0, 3'd0, 0, 1, 1, 32'h10));
        vecs.push_back(mk(32'h20, 1, 0, 3'd0, 0, 1, 1, 32'h10));
        vecs.push_back(mk(32'h20, 1, 1, 3'd0, 0, 1, 1, 32'h10));
        vecs.push_back(mk(32'h20, 1, 0, 3'd0, 1, 0, 1, 32'h14));
        vecs.push_back(mk(32'h24, 1, 0, 3'd0, 0, 1, 1, 32'h14));
        vecs.push_back(mk(32'h24, 1, 1, 3'd0, 0, 1, 1, 32'h14));
        vecs.push_back(mk(32'h24, 1, 1, 3'd0, 1, 0, 1, 32'h18));
        vecs.push_back(mk(32'h28, 0, 1, 3'd0, 1, 1, 1, 32'h1C));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pc, vecs[i].ready, vecs[i].inst_ready, 1'b0, vecs[i].hold);
            checkOutput($sformatf("vec%0d_req_valid", i), 32'(bus.mem_req_valid_o), 32'(vecs[i].exp_req_valid));
            checkOutput($sformatf("vec%0d_stall", i), 32'(pc_stall), 32'(vecs[i].exp_stall));
            checkOutput($sformatf("vec%0d_inst_valid", i), 32'(bus.inst_valid_o), 32'(vecs[i].exp_inst_valid));
            if (vecs[i].exp_req_valid)
                checkOutput($sformatf("vec%0d_req_addr", i), bus.mem_req_addr_o, vecs[i].pc);
            if (vecs[i].exp_inst_valid) begin
                checkOutput($sformatf("vec%0d_inst_addr", i), bus.inst_addr_o, vecs[i].exp_inst_addr);
                checkOutput($sformatf("vec%0d_inst", i), bus.inst_o, mem_word(vecs[i].exp_inst_addr));
            end
            tick();
        end

        // Three fetches in flight when the redirect hits: all three are dropped.
        drain();
        rsp_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h40 + 32'(4 * i), 1'b1, 1'b1, 1'b0, 3'd0);
            checkOutput($sformatf("flush3_issue%0d_stall", i), 32'(pc_stall), 32'd0);
            tick();
        end
        applyStimulus(32'h100, 1'b1, 1'b1, 1'b1, 3'd0);
        checkOutput("flush3_jump_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
        checkOutput("flush3_jump_stall", 32'(pc_stall), 32'd1);
        rsp_en = 1'b1;
        tick();
        runUntilInst(32'h100, "flush3_first");

        // Response landing on the jump cycle with two outstanding: one later drop.
        drain();
        rsp_en = 1'b0;
        applyStimulus(32'h200, 1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        applyStimulus(32'h204, 1'b1, 1'b1, 1'b0, 3'd0);
        rsp_en = 1'b1;
        tick();
        applyStimulus(32'h300, 1'b0, 1'b1, 1'b1, 3'd0);
        checkOutput("jumprsp_rsp_present", 32'(bus.mem_rsp_valid_i), 32'd1);
        rsp_en = 1'b0;
        tick();
        rsp_en = 1'b1;
        runUntilInst(32'h300, "jumprsp_first");

        // Random memory backpressure: decode must see every PC once, in order.
        drain();
        p        = 32'h400;
        exp_next = 32'h400;
        for (int c = 0; c < 60; c++) begin
            r = (c < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus(p, r, 1'b1, 1'b0, 3'd0);
            if (!r) checkOutput($sformatf("rand%0d_stall_notready", c), 32'(pc_stall), 32'd1);
            if (bus.inst_valid_o) begin
                checkOutput($sformatf("rand%0d_inst_addr", c), bus.inst_addr_o, exp_next);
                checkOutput($sformatf("rand%0d_inst", c), bus.inst_o, mem_word(exp_next));
                exp_next += 32'd4;
            end
            stalled = pc_stall;
            tick();
            if (!stalled) p += 32'd4;
        end
        checkOutput("rand_all_delivered", exp_next, p);

        // Asynchronous reset with two buffered entries.
        drain();
        applyStimulus(32'h500, 1'b1, 1'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(32'h504, 1'b1, 1'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(32'h508, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(32'h508, 1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("rst_pre_inst_valid", 32'(bus.inst_valid_o), 32'd1);
        checkOutput("rst_pre_inst_addr", bus.inst_addr_o, 32'h500);
        #1;
        rst = 1'b0;
        #1;
        check_reset("rst_async");
        mem_q.delete();
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;
        tick();
        rst = 1'b1;
        runUntilInst(32'h600, "rst_first");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
